// File: rtl/rv32_pkg.sv
// Shared RV32 writeback definitions: load funct3 encodings, FSM state, datapath width.
// Also holds the load legality/alignment helpers used by the writeback FSM.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Only meaningful for legal funct3 values; bytes are never misaligned.
  function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if ((f3 == F3_LH) || (f3 == F3_LHU)) mis = addr_lo[0];
    else if (f3 == F3_LW)                mis = (addr_lo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Writeback unit bus bundle: result/load descriptor, memory response, RF write port, status.
// master = producer side (execute/memory model), slave = writeback unit.
interface writeback_unit_if #(
  parameter int XLEN   = rv32_pkg::XLEN,
  parameter int REG_AW = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rd;
  logic              in_is_load;
  logic [2:0]        in_funct3;
  logic [1:0]        in_addr_lo;
  logic [XLEN-1:0]   in_result;

  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  logic              rf_we;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_wdata;

  logic              busy;
  logic              misalign;
  logic              illegal;
  logic              stray_rsp;

  modport master (
    output in_valid, in_rd, in_is_load, in_funct3, in_addr_lo, in_result,
    output mem_rvalid, mem_rdata,
    input  in_ready, rf_we, rf_rd, rf_wdata, busy, misalign, illegal, stray_rsp
  );

  modport slave (
    input  in_valid, in_rd, in_is_load, in_funct3, in_addr_lo, in_result,
    input  mem_rvalid, mem_rdata,
    output in_ready, rf_we, rf_rd, rf_wdata, busy, misalign, illegal, stray_rsp
  );

endinterface

// File: rtl/load_extend.sv
// Formats an aligned memory word into load data: byte/half select plus sign/zero extension.
// Purely combinational, no latency, no flow control.
module load_extend #(
  parameter int XLEN = rv32_pkg::XLEN
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o
);
  import rv32_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Drives the RF write port: ALU results retire 1/cycle (1-cycle latency), loads write the cycle after mem_rvalid.
// in_ready drops while a load is outstanding; x0 writes, misaligned and illegal loads are suppressed and flagged.
module writeback_unit #(
  parameter int XLEN   = rv32_pkg::XLEN,
  parameter int REG_AW = 5
) (
  input logic            clk,
  input logic            rst_n,
  writeback_unit_if.slave wb
);
  import rv32_pkg::*;

  wb_state_t         state_q;
  logic [REG_AW-1:0] rd_q;
  logic [2:0]        f3_q;
  logic [1:0]        alo_q;

  logic              rf_we_q;
  logic [REG_AW-1:0] rf_rd_q;
  logic [XLEN-1:0]   rf_wdata_q;
  logic              misalign_q;
  logic              illegal_q;
  logic              stray_q;

  logic [XLEN-1:0]   ext_data;
  logic              accept;
  logic              ld_legal;
  logic              ld_misaligned;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .word_i    (wb.mem_rdata),
    .funct3_i  (f3_q),
    .addr_lo_i (alo_q),
    .data_o    (ext_data)
  );

  always_comb begin
    accept        = wb.in_valid && (state_q == IDLE);
    ld_legal      = f3_legal(wb.in_funct3);
    ld_misaligned = load_misaligned(wb.in_funct3, wb.in_addr_lo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      f3_q       <= '0;
      alo_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      rf_we_q    <= 1'b0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      stray_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          // A response here belongs to no load, even one accepted this same edge.
          stray_q <= wb.mem_rvalid;
          if (accept) begin
            if (!wb.in_is_load) begin
              rf_we_q    <= (wb.in_rd != '0);
              rf_rd_q    <= wb.in_rd;
              rf_wdata_q <= wb.in_result;
            end else if (!ld_legal) begin
              illegal_q <= 1'b1;
            end else if (ld_misaligned) begin
              misalign_q <= 1'b1;
            end else begin
              rd_q    <= wb.in_rd;
              f3_q    <= wb.in_funct3;
              alo_q   <= wb.in_addr_lo;
              state_q <= WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          if (wb.mem_rvalid) begin
            rf_we_q    <= (rd_q != '0);
            rf_rd_q    <= rd_q;
            rf_wdata_q <= ext_data;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb.in_ready  = (state_q == IDLE);
  assign wb.busy      = (state_q == WAIT_MEM);
  assign wb.rf_we     = rf_we_q;
  assign wb.rf_rd     = rf_rd_q;
  assign wb.rf_wdata  = rf_wdata_q;
  assign wb.misalign  = misalign_q;
  assign wb.illegal   = illegal_q;
  assign wb.stray_rsp = stray_q;

endmodule
